// File: rtl/vectored_intc.sv
// vectored_intc: vectored interrupt controller in front of the mips core.
// Captures rising edges on NUM_SRC request lines, picks the lowest-index
// eligible source, and raises one registered `interrupt` with a fixed
// handler address on `vector`. It then tracks that source through int_ack
// and the end-of-interrupt strobe.
//
// Optional feature: define VECTORED_INTC_MASK_EN to build a writable mask
// register. Without it, `mask` reads all ones and mask_we/mask_wd are unused.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   irq_src        device request lines (already synchronous to clk)
//   int_ack        acknowledge from the core
//   eoi            one-cycle end-of-interrupt strobe from the handler return
//   mask_we/wd     mask register write (1 = source enabled)
//   interrupt      registered request to the core
//   vector         handler address of the presented or in-service source
//   active_id      id of the presented or in-service source
//   pending        captured edge flags
//   mask           current mask
module vectored_intc #(
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wd,
  output logic               interrupt,
  output logic [31:0]        vector,
  output logic [3:0]         active_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               interrupt_q, interrupt_d;
  logic [31:0]        vector_q, vector_d;
  logic [3:0]         active_id_q, active_id_d;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;
  logic [3:0]         win_id;

  // Mask register (optional)
`ifdef VECTORED_INTC_MASK_EN
  logic [NUM_SRC-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (mask_we) mask_d = mask_wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_q <= '1;
    else       mask_q <= mask_d;
  end

  assign mask = mask_q;
`else
  logic unused_mask_in;
  assign unused_mask_in = ^{mask_we, mask_wd};
  assign mask = '1;
`endif

  // Arbitration uses the registered mask, so a write in the same cycle as
  // the IDLE decision only takes effect on the following cycle.
  assign eligible = pending_q & mask;

  // Lowest index wins: scan downward so the last hit is the smallest id.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (eligible[i]) win_id = 4'(i);
  end

  // One-hot clear of the acknowledged source.
  always_comb begin
    ack_clr = '0;
    if (state_q == REQ && int_ack)
      for (int i = 0; i < NUM_SRC; i++)
        ack_clr[i] = (active_id_q == 4'(i));
  end

  // A new edge is ORed in after the clear, so a set in the ack cycle wins.
  assign pending_d = (pending_q & ~ack_clr) | (irq_src & ~irq_q);

  always_comb begin
    state_d     = state_q;
    interrupt_d = interrupt_q;
    vector_d    = vector_q;
    active_id_d = active_id_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          active_id_d = win_id;
          vector_d    = VEC_BASE + {28'd0, win_id} * VEC_STRIDE;
          interrupt_d = 1'b1;
          state_d     = REQ;
        end
      end
      // Request is frozen until acknowledged: no preemption, no withdrawal.
      REQ: begin
        if (int_ack) begin
          interrupt_d = 1'b0;
          state_d     = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: begin
        interrupt_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      irq_q       <= '0;
      pending_q   <= '0;
      interrupt_q <= 1'b0;
      vector_q    <= '0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_src;
      pending_q   <= pending_d;
      interrupt_q <= interrupt_d;
      vector_q    <= vector_d;
      active_id_q <= active_id_d;
    end
  end

  assign interrupt = interrupt_q;
  assign vector    = vector_q;
  assign active_id = active_id_q;
  assign pending   = pending_q;

endmodule

// File: doc/vectored_intc.md
# vectored_intc

Vectored interrupt controller that drives the processor's single `interrupt` request line and consumes its `int_ack` acknowledge. It captures rising edges on up to `NUM_SRC` device request lines, prioritises them, presents one request at a time with a stable handler address on `vector`, and tracks the in-service source until the handler signals end-of-interrupt. It sits between peripherals and the `mips` core, alongside the instruction and data memories in the top level.

## Interface
- `NUM_SRC`, 4: number of request sources, 1..16.
- `VEC_BASE`, 32'h0000_0100: handler address for source 0.
- `VEC_STRIDE`, 32'h0000_0010: address spacing between consecutive handlers.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `irq_src` in NUM_SRC: device request lines, already synchronous to `clk`.
- `int_ack` in 1: acknowledge from the core, sampled on `posedge clk`.
- `eoi` in 1: one-cycle end-of-interrupt strobe, issued when the handler returns (JEPC).
- `mask_we` in 1: mask register write enable.
- `mask_wd` in NUM_SRC: mask write data, 1 = enabled.
- `interrupt` out 1: registered request to the core.
- `vector` out 32: handler address, valid while `interrupt` = 1 and in SERVICE.
- `active_id` out 4: id of the presented or in-service source.
- `pending` out NUM_SRC: pending flags.
- `mask` out NUM_SRC: current mask.

## Operation
- Edge capture:
  - `irq_q` registers `irq_src` every cycle.
  - `pending[i]` sets when `irq_src[i]` & ~`irq_q[i]`.
  - Levels held high do not re-trigger.
  - Pending latches regardless of mask.
- Eligible set = `pending & mask`. Priority is fixed: lowest index wins.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if eligible ≠ 0, latch the winner into `active_id`, set `vector` = VEC_BASE + id*VEC_STRIDE (32-bit, wraps modulo 2^32), set `interrupt` = 1, go to REQ.
  - REQ:
    - Hold `interrupt`, `vector` and `active_id` frozen. No preemption by higher-priority arrivals. Masking the active source does not withdraw the request.
    - On `int_ack`: clear `pending[active_id]`, set `interrupt` = 0, go to SERVICE.
  - SERVICE: `interrupt` = 0 and `vector` is held. On `eoi`, go to IDLE. A new request can be presented no earlier than the cycle after IDLE is entered.
- Ignored inputs: `int_ack` in IDLE or SERVICE; `eoi` in IDLE or REQ.
- Simultaneous events:
  - Rising edge on `active_id` in the same cycle as the clearing `int_ack`: pending stays set, because the set wins over the clear.
  - `mask_we` in the same cycle as the IDLE→REQ decision: arbitration uses the old mask.
- Reset, at any time including mid-handshake:
  - `interrupt` = 0, `vector` = 0, `active_id` = 0, `pending` = 0, `irq_q` = 0.
  - `mask` = all ones, FSM = IDLE.

## Timing
- Source rising edge sampled at posedge k: `pending` is visible after k, and `interrupt` = 1 after posedge k+1. Latency is 2 cycles.
- `int_ack` sampled at posedge m: `interrupt` = 0 and `pending` bit cleared after m.
- `eoi` at posedge n: IDLE after n. The next `interrupt` can rise after n+1.
- `mask` updates at the posedge where `mask_we` = 1.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `VECTORED_INTC_MASK_EN` defined:
  - The mask register exists and is written via `mask_we`/`mask_wd`.
  - It resets to all ones.
- `VECTORED_INTC_MASK_EN` undefined:
  - No mask flops.
  - `mask` output is tied to all ones.
  - `mask_we` and `mask_wd` are ignored.
  - Eligible set = `pending`.

## Test plan
All scenarios use NUM_SRC=4, VEC_BASE=0x100, VEC_STRIDE=0x10.
- Basic handshake: rise `irq_src[2]` → after 2 edges `interrupt`=1, `vector`=0x120, `active_id`=2. Pulse `int_ack` → `interrupt`=0, `pending[2]`=0. Pulse `eoi` → IDLE.
- Priority: rise `irq_src[3]` and `irq_src[1]` together → `vector`=0x110 first. After `eoi`, `vector`=0x130 two cycles later.
- No preemption: in REQ for source 2, rise `irq_src[0]` → `vector` stays 0x120 until `int_ack`. After `eoi`, source 0 is presented with `vector`=0x100.
- Mask (with `VECTORED_INTC_MASK_EN`): write `mask`=4'b1110, rise `irq_src[0]` → `pending`=4'b0001, `interrupt` stays 0. Write `mask`=4'b1111 → `interrupt`=1 two edges later, `vector`=0x100.
- Edge-only capture and set-wins: hold `irq_src[1]` high for 20 cycles → exactly one request. Re-edge `irq_src[1]` in the `int_ack` cycle → `pending[1]` remains 1.
- Reset mid-REQ: assert `reset` while `interrupt`=1 → all outputs 0, `mask`=4'b1111 immediately (asynchronous). Ignored `int_ack`/`eoi` after reset cause no state change.
